// File: rtl/sap_board_io.sv
// sap_board_io: board-level run control and I/O for the SAP core.
// Generates the core clock-enable (free-run divider or debounced single
// step), stretches reset into a fixed-length core clear, latches the core
// output port and drives a selectable LED bank.
//
// Handshake: there is no valid/ready pair here. cpu_ce is a one-cycle
// strobe; the output port is captured on the edge where cpu_ce and out_ld
// are both high, and out_valid marks the cycle after that capture.
module sap_board_io #(
    parameter int OUT_W      = 8,
    parameter int LED_N      = 5,
    parameter int DIV        = 4,
    parameter int CLR_CYCLES = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             halt,
    input  logic             out_ld,
    input  logic [OUT_W-1:0] out_data,
    input  logic [1:0]       led_sel,
    output logic             cpu_ce,
    output logic             core_clr,
    output logic [OUT_W-1:0] out_reg,
    output logic             out_valid,
    output logic [LED_N-1:0] led
);

    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_d;
    logic             mode_q;
    logic             sync1_q, sync2_q, step_d_q, step_rise_q;
    logic             heartbeat_q;
    logic [LED_N-1:0] led_d;

    // Clear-stretcher state and edge counter registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= HOLD;
            clr_cnt_q <= '0;
            core_clr  <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            core_clr  <= (state_d == HOLD);
        end
    end

    // Clear-stretcher next state: leave HOLD on the CLR_CYCLES-th edge
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            HOLD: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d   = HOLD;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Step button synchronizer, registered rising-edge detect, mode sample
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            step_d_q    <= 1'b0;
            step_rise_q <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            sync1_q     <= step_btn;
            sync2_q     <= sync1_q;
            step_d_q    <= sync2_q;
            step_rise_q <= sync2_q & ~step_d_q;
            mode_q      <= run_mode;
        end
    end

    // Clock-enable source: divider in free-run, step pulse otherwise.
    // A step pulse that lands during halt, HOLD or a mode switch is dropped.
    always_comb begin
        div_d = div_q;
        ce_d  = 1'b0;
        if (state_q != RUN) begin
            div_d = '0;
        end else if (run_mode != mode_q) begin
            div_d = '0;
        end else if (halt) begin
            div_d = div_q;
        end else if (run_mode) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                ce_d  = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            ce_d = step_rise_q;
        end
    end

    // Divider and clock-enable registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_q  <= '0;
            cpu_ce <= 1'b0;
        end else begin
            div_q  <= div_d;
            cpu_ce <= ce_d;
        end
    end

    // Output port latch, load strobe and heartbeat, all keyed on cpu_ce
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_reg     <= '0;
            out_valid   <= 1'b0;
            heartbeat_q <= 1'b0;
        end else begin
            out_valid <= cpu_ce & out_ld;
            if (cpu_ce && out_ld) begin
                out_reg <= out_data;
            end
            if (cpu_ce) begin
                heartbeat_q <= ~heartbeat_q;
            end
        end
    end

    // LED source select
    always_comb begin
        led_d = '0;
        case (led_sel)
            2'd0: led_d = out_reg[LED_N-1:0];
            2'd1: led_d = out_reg[OUT_W-1 -: LED_N];
            2'd2: begin
                for (int i = 0; i < LED_N; i++) begin
                    if (i >= 3) begin
                        led_d[i] = heartbeat_q;
                    end
                end
                led_d[0] = core_clr;
                led_d[1] = halt;
                led_d[2] = run_mode;
            end
            default: led_d = '0;
        endcase
    end

    // LED drive register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            led <= '0;
        end else begin
            led <= led_d;
        end
    end

endmodule

// File: tb/tb_sap_board_io.sv
// Directed testbench for sap_board_io with default parameters
// (OUT_W=8, LED_N=5, DIV=4, CLR_CYCLES=16).
module tb_sap_board_io;

    logic       clk;
    logic       clr;
    logic       run_mode;
    logic       step_btn;
    logic       halt;
    logic       out_ld;
    logic [7:0] out_data;
    logic [1:0] led_sel;
    logic       cpu_ce;
    logic       core_clr;
    logic [7:0] out_reg;
    logic       out_valid;
    logic [4:0] led;

    int n_checks;
    int n_fail;

    sap_board_io #(
        .OUT_W(8), .LED_N(5), .DIV(4), .CLR_CYCLES(16)
    ) dut (
        .clk(clk), .clr(clr), .run_mode(run_mode), .step_btn(step_btn),
        .halt(halt), .out_ld(out_ld), .out_data(out_data), .led_sel(led_sel),
        .cpu_ce(cpu_ce), .core_clr(core_clr), .out_reg(out_reg),
        .out_valid(out_valid), .led(led)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // one clock edge, then sample 1 time unit later
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b0; run_mode = 1'b0; step_btn = 1'b0; halt = 1'b0;
        out_ld = 1'b0; out_data = 8'h00; led_sel = 2'd0;
        repeat (3) tick();
        n_checks++;
        if (core_clr !== 1'b1 || cpu_ce !== 1'b0 || out_reg !== 8'h00 ||
            out_valid !== 1'b0 || led !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: clr=%b ce=%b out=%h ov=%b led=%b required 1 0 00 0 00000",
                     core_clr, cpu_ce, out_reg, out_valid, led);
        end
        clr = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            tick();
            n_checks++;
            if (core_clr !== (n < 16)) begin
                n_fail++;
                $display("FAIL stretch edge %0d: core_clr=%b required %b", n, core_clr, n < 16);
            end
            n_checks++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL stretch_ce edge %0d: cpu_ce=%b required 0", n, cpu_ce);
            end
        end
    endtask

    task automatic test_free_run_halt;
        logic exp;
        run_mode = 1'b1;
        // edge 1 sees the mode switch; wraps land on edges 5, 9, 13 ...
        for (int n = 1; n <= 40; n++) begin
            tick();
            exp = (n >= 5) && (((n - 5) % 4) == 0);
            n_checks++;
            if (cpu_ce !== exp) begin
                n_fail++;
                $display("FAIL free_run edge %0d: cpu_ce=%b required %b", n, cpu_ce, exp);
            end
        end
        // divider sits at 3 after edge 40; freeze it for 10 edges
        halt = 1'b1;
        for (int n = 41; n <= 50; n++) begin
            tick();
            n_checks++;
            if (cpu_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL halt edge %0d: cpu_ce=%b required 0", n, cpu_ce);
            end
        end
        halt = 1'b0;
        // frozen count 3 wraps on the first edge after release
        for (int n = 51; n <= 58; n++) begin
            tick();
            exp = (n == 51) || (n == 55);
            n_checks++;
            if (cpu_ce !== exp) begin
                n_fail++;
                $display("FAIL halt_resume edge %0d: cpu_ce=%b required %b", n, cpu_ce, exp);
            end
        end
    endtask

    task automatic test_step;
        int pulses;
        pulses = 0;
        run_mode = 1'b0;
        repeat (3) tick();
        for (int press = 0; press < 2; press++) begin
            step_btn = 1'b1;
            for (int t = 1; t <= 50; t++) begin
                tick();
                if (cpu_ce === 1'b1) pulses++;
                n_checks++;
                if (cpu_ce !== (t == 4)) begin
                    n_fail++;
                    $display("FAIL step press %0d tick %0d: cpu_ce=%b required %b",
                             press, t, cpu_ce, t == 4);
                end
            end
            step_btn = 1'b0;
            for (int t = 1; t <= 10; t++) begin
                tick();
                if (cpu_ce === 1'b1) pulses++;
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL step_count: pulses=%0d required 2", pulses);
        end
    endtask

    task automatic test_step_halt;
        int pulses;
        pulses = 0;
        halt = 1'b1;
        tick();
        step_btn = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (cpu_ce === 1'b1) pulses++;
        end
        step_btn = 1'b0;
        repeat (10) begin
            tick();
            if (cpu_ce === 1'b1) pulses++;
        end
        halt = 1'b0;
        repeat (20) begin
            tick();
            if (cpu_ce === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL step_during_halt: pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_out_latch;
        run_mode = 1'b1;
        // mode switch at edge 1; cpu_ce high after edges 5 and 9
        tick(); tick();
        out_ld = 1'b1; out_data = 8'hA5;
        tick(); tick(); tick();
        n_checks++;
        if (cpu_ce !== 1'b1 || out_reg !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latch_ignored: ce=%b out=%h ov=%b required 1 00 0",
                     cpu_ce, out_reg, out_valid);
        end
        tick();
        n_checks++;
        if (out_reg !== 8'hA5 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latch_load: out=%h ov=%b required a5 1", out_reg, out_valid);
        end
        out_data = 8'h5A;
        tick();
        n_checks++;
        if (out_reg !== 8'hA5 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latch_hold: out=%h ov=%b required a5 0", out_reg, out_valid);
        end
        out_ld = 1'b0;
        run_mode = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_leds;
        logic hb0;
        led_sel = 2'd0;
        tick();
        n_checks++;
        if (led !== 5'b00101) begin
            n_fail++;
            $display("FAIL led_sel0: led=%b required 00101", led);
        end
        led_sel = 2'd1;
        tick();
        n_checks++;
        if (led !== 5'b10100) begin
            n_fail++;
            $display("FAIL led_sel1: led=%b required 10100", led);
        end
        led_sel = 2'd3;
        tick();
        n_checks++;
        if (led !== 5'b00000) begin
            n_fail++;
            $display("FAIL led_sel3: led=%b required 00000", led);
        end
        // status view in free-run: pulses after edges 5 and 9,
        // heartbeat flips on edges 6 and 10, LEDs follow on 7 and 11
        led_sel = 2'd2;
        run_mode = 1'b1;
        tick(); tick();
        hb0 = led[3];
        n_checks++;
        if (led[2:0] !== 3'b100 || led[4] !== hb0) begin
            n_fail++;
            $display("FAIL led_status: led=%b required %b%b100", led, hb0, hb0);
        end
        repeat (5) tick();
        n_checks++;
        if (led[4:3] !== {2{~hb0}}) begin
            n_fail++;
            $display("FAIL led_heartbeat1: led[4:3]=%b required %b", led[4:3], {2{~hb0}});
        end
        repeat (4) tick();
        n_checks++;
        if (led[4:3] !== {2{hb0}}) begin
            n_fail++;
            $display("FAIL led_heartbeat2: led[4:3]=%b required %b", led[4:3], {2{hb0}});
        end
        halt = 1'b1;
        tick();
        n_checks++;
        if (led[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL led_halt: led[1]=%b required 1", led[1]);
        end
        halt = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset;
        logic exp;
        led_sel = 2'd0;
        out_ld = 1'b1; out_data = 8'h3C;
        repeat (8) tick();
        out_ld = 1'b0;
        tick();
        n_checks++;
        if (out_reg !== 8'h3C || led !== 5'b11100) begin
            n_fail++;
            $display("FAIL preload_3c: out=%h led=%b required 3c 11100", out_reg, led);
        end
        #2 clr = 1'b0;
        #1;
        n_checks++;
        if (out_reg !== 8'h00 || led !== 5'b0 || cpu_ce !== 1'b0 || core_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: out=%h led=%b ce=%b clr=%b required 00 00000 0 1",
                     out_reg, led, cpu_ce, core_clr);
        end
        #2 clr = 1'b1;
        // edges 1..15 hold, edge 16 enters RUN, divider wraps on edge 20
        for (int n = 1; n <= 21; n++) begin
            tick();
            n_checks++;
            if (core_clr !== (n < 16)) begin
                n_fail++;
                $display("FAIL restretch edge %0d: core_clr=%b required %b", n, core_clr, n < 16);
            end
            exp = (n == 20);
            n_checks++;
            if (cpu_ce !== exp) begin
                n_fail++;
                $display("FAIL restretch_ce edge %0d: cpu_ce=%b required %b", n, cpu_ce, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_free_run_halt();
        test_step();
        test_step_halt();
        test_out_latch();
        test_leds();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
